// File: rtl/ccff_stream_loader_pkg.sv
// Shared types and helpers for the configuration-chain stream loader.
package ccff_stream_loader_pkg;

    // Loader control states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Bits needed to hold a count of 0..n-1 (never less than one bit).
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ccff_rb_packer.sv
// Collects chain-tail bits into readback words, bit 0 first, and strobes
// rb_valid the cycle after a word fills or the final chain bit is captured.
module ccff_rb_packer
    import ccff_stream_loader_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cap_en,
    input  logic              cap_bit,
    input  logic              last,
    output logic              word_end,
    output logic              rb_valid,
    output logic [WORD_W-1:0] rb_data
);

    localparam int POS_W = cnt_width(WORD_W);

    logic [POS_W-1:0]  pos_q, pos_d;
    logic [WORD_W-1:0] acc_q, acc_d;
    logic [WORD_W-1:0] rb_data_q, rb_data_d;
    logic              rb_valid_q, rb_valid_d;

    // Capture position advances per shifted bit; a word closes when full or on the last chain bit.
    always_comb begin
        acc_d      = acc_q;
        pos_d      = pos_q;
        rb_data_d  = rb_data_q;
        rb_valid_d = 1'b0;
        word_end   = cap_en && ((pos_q == POS_W'(WORD_W - 1)) || last);
        if (cap_en) begin
            acc_d[pos_q] = cap_bit;
            if (word_end) begin
                // Accumulator is cleared after each word, so unfilled high bits read as 0.
                rb_data_d  = acc_d;
                rb_valid_d = 1'b1;
                acc_d      = '0;
                pos_d      = '0;
            end else begin
                pos_d = pos_q + 1'b1;
            end
        end
    end

    // Readback state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q      <= '0;
            acc_q      <= '0;
            rb_data_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            pos_q      <= pos_d;
            acc_q      <= acc_d;
            rb_data_q  <= rb_data_d;
            rb_valid_q <= rb_valid_d;
        end
    end

    assign rb_valid = rb_valid_q;
    assign rb_data  = rb_data_q;

endmodule

// File: rtl/ccff_stream_loader.sv
// Streams bitstream words serially into a configuration flip-flop chain and
// returns the bits falling out of the chain tail as readback words.
module ccff_stream_loader
    import ccff_stream_loader_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 1024
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              word_valid,
    input  logic [WORD_W-1:0] word_data,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
    output logic              rb_valid,
    output logic [WORD_W-1:0] rb_data,
    output logic              busy,
    output logic              done,
    output logic              err_start
);

    localparam int BCNT_W = cnt_width(CHAIN_LEN + 1);

    logic [1:0]        rst_sync_q;
    logic              rst_n;
    state_t            state_q, state_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [BCNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic              err_q, err_d;
    logic              last_bit;
    logic              word_end;

    // Reset asserts immediately but releases only after two prog_clk edges.
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n    = rst_sync_q[1];
    assign last_bit = (bit_cnt_q == BCNT_W'(CHAIN_LEN - 1));

    // Next-state, datapath and output decode for the load sequence.
    always_comb begin
        state_d       = state_q;
        shift_d       = shift_q;
        bit_cnt_d     = bit_cnt_q;
        err_d         = err_q;
        word_ready    = 1'b0;
        ccff_head     = 1'b0;
        ccff_shift_en = 1'b0;
        done          = 1'b0;
        busy          = (state_q != ST_IDLE);
        if (start && (state_q != ST_IDLE)) begin
            err_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_FETCH;
                    bit_cnt_d = '0;
                end
            end
            ST_FETCH: begin
                // Starved source simply holds here; the chain does not advance.
                word_ready = 1'b1;
                if (word_valid) begin
                    shift_d = word_data;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                ccff_head     = shift_q[0];
                ccff_shift_en = 1'b1;
                shift_d       = shift_q >> 1;
                bit_cnt_d     = bit_cnt_q + 1'b1;
                // Word boundaries line up with readback boundaries, so the packer's
                // word_end also marks the end of the current (possibly partial) word.
                if (word_end) begin
                    state_d = last_bit ? ST_DONE : ST_FETCH;
                end
            end
            ST_DONE: begin
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control and datapath registers.
    always_ff @(posedge prog_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            err_q     <= err_d;
        end
    end

    assign err_start = err_q;

    ccff_rb_packer #(
        .WORD_W (WORD_W)
    ) u_rb_packer (
        .clk      (prog_clk),
        .rst_n    (rst_n),
        .cap_en   (ccff_shift_en),
        .cap_bit  (ccff_tail),
        .last     (last_bit),
        .word_end (word_end),
        .rb_valid (rb_valid),
        .rb_data  (rb_data)
    );

endmodule
